// File: rtl/rr_sel_arbiter4_if.sv
// Bundles the request/grant signals of the 4-channel round-robin select arbiter.
//
// Signals:
//   req        per-channel level request, bit i = channel i     (master -> slave)
//   done       single-cycle completion pulse from current owner (master -> slave)
//   sel        registered 2-bit mux select of the granted channel (slave -> master)
//   gnt        registered one-hot grant, 0000 when idle            (slave -> master)
//   gnt_valid  registered, high while a grant is active            (slave -> master)
//   timeout    registered one-cycle pulse on forced release        (slave -> master)
//
// The arbiter connects through the slave modport; requesters and the mux stage
// use the master modport.
interface rr_sel_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_sel_arbiter4.sv
// Four-requester round-robin arbiter driving the registered select of the 4:1
// data mux that follows it. One channel is granted at a time and sel is held
// stable for the whole grant. A grant ends on done, on withdrawal of the
// owner's request, or after MAX_HOLD cycles. Every hand-over passes through at
// least one idle cycle so sel never moves while gnt_valid is high.
//
// Parameters:
//   MAX_HOLD  maximum cycles a grant may last before forced release; 0 disables
//   CNT_W     hold counter width, 2**CNT_W must be >= MAX_HOLD
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   rr_sel_arbiter4_if slave modport (req, done in; sel, gnt, gnt_valid,
//         timeout out, all outputs straight from flops)
module rr_sel_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic              clk,
  input logic              rst,
  rr_sel_arbiter4_if.slave bus
);

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Hold count at which the timeout fires; unused when MAX_HOLD is 0.
  localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HoldMax  = '1;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  // Round-robin pick: first requester scanning upward from last_q + 1.
  logic [1:0] pick;
  logic       pick_found;
  logic [1:0] cand;

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found && bus.req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Release causes, highest priority first.
  logic rel_done;
  logic rel_drop;
  logic rel_hold;

  always_comb begin
    rel_done = bus.done;
    rel_drop = !bus.req[sel_q];
    rel_hold = (MAX_HOLD != 0) && (hold_q == HoldLast);
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done is ignored here; only requests matter.
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d   = StIdle;
          gnt_d     = 4'b0000;
          last_d    = sel_q;
          hold_d    = '0;
          // Flag only a pure timeout, not a release that was happening anyway.
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;  // channel 0 wins first after reset
      gnt_q     <= 4'b0000;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Single-bit state register doubles as the grant-valid flop.
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = (state_q == StGrant);
  assign bus.timeout   = timeout_q;

  // Structural invariants of the grant outputs.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_match : assert property (@(posedge clk) disable iff (rst)
    (state_q == StGrant) == (gnt_q != 4'b0000));
  a_gnt_sel     : assert property (@(posedge clk) disable iff (rst)
    (state_q == StGrant) |-> (gnt_q == (4'b0001 << sel_q)));

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
module tb_rr_sel_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_v = 4'b0000;
  logic       done_v = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter4_if bus_a ();
  rr_sel_arbiter4_if bus_b ();

  rr_sel_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rr_sel_arbiter4 #(.MAX_HOLD(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Packed observation: {gnt_valid, gnt, sel, timeout}
  logic [7:0] obs_a;
  logic [7:0] obs_b;
  assign obs_a = {bus_a.gnt_valid, bus_a.gnt, bus_a.sel, bus_a.timeout};
  assign obs_b = {bus_b.gnt_valid, bus_b.gnt, bus_b.sel, bus_b.timeout};

  // Reference model, index 0 = MAX_HOLD 8, index 1 = MAX_HOLD 0.
  int m_max[2] = '{8, 0};
  bit m_valid[2];
  int m_sel[2];
  int m_last[2];
  int m_hold[2];
  bit m_to[2];

  task automatic model_step(input int d);
    bit rel_t;
    if (rst) begin
      m_valid[d] = 0; m_sel[d] = 0; m_last[d] = 3; m_hold[d] = 0; m_to[d] = 0;
    end else if (!m_valid[d]) begin
      m_to[d] = 0;
      for (int k = 1; k <= 4; k++) begin
        if (req_v[(m_last[d] + k) % 4]) begin
          m_valid[d] = 1;
          m_sel[d]   = (m_last[d] + k) % 4;
          m_hold[d]  = 0;
          break;
        end
      end
    end else begin
      rel_t = (m_max[d] != 0) && (m_hold[d] == m_max[d] - 1);
      if (done_v || !req_v[m_sel[d]] || rel_t) begin
        m_to[d]    = rel_t && !done_v && req_v[m_sel[d]];
        m_valid[d] = 0;
        m_last[d]  = m_sel[d];
        m_hold[d]  = 0;
      end else begin
        m_to[d] = 0;
        if (m_hold[d] < 15) m_hold[d]++;
      end
    end
  endtask

  function automatic logic [7:0] expv(input int d);
    logic [3:0] g;
    logic [1:0] s;
    s = 2'(m_sel[d]);
    g = m_valid[d] ? (4'b0001 << s) : 4'b0000;
    return {m_valid[d], g, s, m_to[d]};
  endfunction

  // Drive inputs on the falling edge, advance one rising edge, sample 1 unit later.
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    @(negedge clk);
    req_v  = r;
    done_v = d;
    rst    = rs;
    bus_a.req  = r;
    bus_a.done = d;
    bus_b.req  = r;
    bus_b.done = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      checks++;
      if (obs_a !== 8'h00) begin
        errors++; $display("FAIL reset_hold: got %b expected %b", obs_a, 8'h00);
      end
    end
    step(4'b1111, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_first_grant: got %b expected %b", obs_a,
                         {1'b1, 4'b0001, 2'd0, 1'b0});
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] s;
    logic [3:0] oh;
    step(4'b0000, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      s  = 2'(g % 4);
      oh = 4'b0001 << s;
      step(4'b1111, 1'b0, 1'b0);
      checks++;
      if (obs_a !== {1'b1, oh, s, 1'b0}) begin
        errors++; $display("FAIL rr_grant%0d_c1: got %b expected %b", g, obs_a, {1'b1, oh, s, 1'b0});
      end
      step(4'b1111, 1'b0, 1'b0);
      checks++;
      if (obs_a !== {1'b1, oh, s, 1'b0}) begin
        errors++; $display("FAIL rr_grant%0d_c2: got %b expected %b", g, obs_a, {1'b1, oh, s, 1'b0});
      end
      step(4'b1111, 1'b1, 1'b0);
      checks++;
      if (obs_a !== {1'b0, 4'b0000, s, 1'b0}) begin
        errors++; $display("FAIL rr_bubble%0d: got %b expected %b", g, obs_a, {1'b0, 4'b0000, s, 1'b0});
      end
    end
  endtask

  task automatic test_single_drop;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0100, 2'd2, 1'b0}) begin
      errors++; $display("FAIL single_grant: got %b expected %b", obs_a, {1'b1, 4'b0100, 2'd2, 1'b0});
    end
    step(4'b0000, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b0, 4'b0000, 2'd2, 1'b0}) begin
      errors++; $display("FAIL single_drop: got %b expected %b", obs_a, {1'b0, 4'b0000, 2'd2, 1'b0});
    end
  endtask

  task automatic test_timeout;
    int high;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0);
    high = bus_a.gnt_valid ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0011, 1'b0, 1'b0);
      if (!bus_a.gnt_valid) break;
      high++;
    end
    checks++;
    if (high !== 8) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected 8", high);
    end
    checks++;
    if (obs_a !== {1'b0, 4'b0000, 2'd0, 1'b1}) begin
      errors++; $display("FAIL timeout_pulse: got %b expected %b", obs_a, {1'b0, 4'b0000, 2'd0, 1'b1});
    end
    step(4'b0011, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0010, 2'd1, 1'b0}) begin
      errors++; $display("FAIL timeout_next: got %b expected %b", obs_a, {1'b1, 4'b0010, 2'd1, 1'b0});
    end
  endtask

  task automatic test_done_at_limit;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(4'b0011, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL limit_hold: got %b expected %b", obs_a, {1'b1, 4'b0001, 2'd0, 1'b0});
    end
    step(4'b0011, 1'b1, 1'b0);
    checks++;
    if (obs_a !== {1'b0, 4'b0000, 2'd0, 1'b0}) begin
      errors++; $display("FAIL limit_done: got %b expected %b", obs_a, {1'b0, 4'b0000, 2'd0, 1'b0});
    end
  endtask

  task automatic test_no_timeout;
    int drops;
    drops = 0;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (obs_b !== {1'b1, 4'b0001, 2'd0, 1'b0}) drops++;
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL nohold_model_a cyc%0d: got %b expected %b", i, obs_a, expv(0));
      end
    end
    checks++;
    if (drops !== 0) begin
      errors++; $display("FAIL nohold_b: got %0d released cycles expected 0", drops);
    end
  endtask

  task automatic test_reset_mid_grant;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0100, 2'd2, 1'b0}) begin
      errors++; $display("FAIL mid_grant: got %b expected %b", obs_a, {1'b1, 4'b0100, 2'd2, 1'b0});
    end
    step(4'b1111, 1'b0, 1'b1);
    checks++;
    if (obs_a !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got %b expected %b", obs_a, 8'h00);
    end
    step(4'b1111, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL mid_after: got %b expected %b", obs_a, {1'b1, 4'b0001, 2'd0, 1'b0});
    end
  endtask

  task automatic test_random;
    logic [3:0] r;
    logic       d;
    logic       rs;
    r = 4'b0000;
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      d  = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 63) == 0);
      step(r, d, rs);
      checks++;
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL rand_a cyc%0d: got %b expected %b", i, obs_a, expv(0));
      end
      checks++;
      if (obs_b !== expv(1)) begin
        errors++; $display("FAIL rand_b cyc%0d: got %b expected %b", i, obs_b, expv(1));
      end
      checks++;
      if (!$onehot0(bus_a.gnt) || (bus_a.gnt_valid !== (bus_a.gnt != 4'b0000)) ||
          (bus_a.gnt_valid && (bus_a.gnt !== (4'b0001 << bus_a.sel)))) begin
        errors++; $display("FAIL rand_inv_a cyc%0d: got %b expected consistent grant", i, obs_a);
      end
    end
  endtask

  initial begin
    m_valid = '{0, 0}; m_sel = '{0, 0}; m_last = '{3, 3}; m_hold = '{0, 0}; m_to = '{0, 0};
    bus_a.req = 4'b0000; bus_a.done = 1'b0;
    bus_b.req = 4'b0000; bus_b.done = 1'b0;
    test_reset();
    test_round_robin();
    test_single_drop();
    test_timeout();
    test_done_at_limit();
    test_no_timeout();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
Four-requester round-robin arbiter that generates the registered 2-bit select for the 4:1 data mux stage directly downstream. It grants one channel at a time and holds the select stable for the whole grant. The grant is released on completion, on request withdrawal, or on a hold timeout. Every hand-over inserts a one-cycle bubble so the mux select never changes while a grant is active.

Parameters:
MAX_HOLD, 8, maximum cycles a grant may be held before forced release; 0 disables the timeout.
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  per-channel request, level-sensitive, bit i = channel i
done  input  1  current owner finished; single-cycle pulse, sampled only while gnt_valid=1
sel  output  2  registered mux select = index of granted channel; holds last value when idle
gnt  output  4  registered one-hot grant, 0000 when idle
gnt_valid  output  1  registered, high while a grant is active
timeout  output  1  registered, one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything:
  - state=IDLE, sel=00, gnt=0000, gnt_valid=0, timeout=0, hold_cnt=0.
  - last pointer=3, so channel 0 has first priority after reset.
  - Reset applied mid-grant takes effect at that same edge; no partial completion.
- States: IDLE, GRANT.
- IDLE:
  - req=0000 -> stay IDLE; sel holds its value; gnt=0000.
  - Any req bit set -> select the first set bit scanning (last+1) mod 4 upward, wrapping 3->0.
  - On the next edge: GRANT, sel=index, gnt=one-hot(index), gnt_valid=1, hold_cnt=0.
  - Latency: req sampled high at edge N -> gnt_valid=1 after edge N.
- GRANT: at each edge, evaluate release conditions in this priority order:
  - (a) done=1.
  - (b) req[sel]=0.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- Release (any of a, b, c) at edge N:
  - After edge N: IDLE, gnt_valid=0, gnt=0000, last=sel, sel unchanged, hold_cnt=0.
  - timeout=1 for exactly one cycle only if (c) is the cause and neither (a) nor (b) holds; otherwise timeout=0.
- No release: stay GRANT; hold_cnt increments and saturates (never wraps); sel/gnt stable.
- Bubble: at least one IDLE cycle between consecutive grants, even back-to-back to different channels.
- The just-released channel may be re-granted immediately after the bubble if it is the only requester.
- done while IDLE is ignored.
- Changes to req bits other than req[sel] during GRANT have no effect until the next IDLE arbitration.
- A grant therefore lasts at most MAX_HOLD cycles with gnt_valid=1 (MAX_HOLD!=0).
- Invariants, checked every cycle:
  - gnt has at most one bit set.
  - gnt_valid==(gnt!=0000).
  - gnt_valid=1 implies gnt==one-hot(sel).
- sel, gnt, gnt_valid and timeout are driven only from flops; no combinational path from any input to any output.

Test Plan:
1. rst=1 for 2 cycles with req=1111 -> sel=00, gnt=0000, gnt_valid=0, timeout=0 throughout; first grant after release of rst goes to ch0 (sel=00).
2. req=1111 held; done pulsed on the 2nd cycle of every grant -> grant order ch0,ch1,ch2,ch3,ch0 (sel 00,01,10,11,00); exactly one gnt_valid=0 cycle between grants.
3. req=0100 only -> gnt_valid=1, sel=10, gnt=0100 one cycle later; drop req[2] -> next cycle gnt_valid=0, gnt=0000, sel stays 10, timeout=0.
4. MAX_HOLD=8, req=0011 held, done=0 -> ch0 gnt_valid high exactly 8 cycles; timeout=1 for one cycle; after the bubble, ch1 is granted (sel=01).
5. MAX_HOLD=8, done=1 on the same edge hold_cnt reaches 7 -> release with timeout=0; MAX_HOLD=0 with req held and done=0 for 100 cycles -> grant never released.
6. Grant active on ch2, assert rst one cycle -> next cycle all outputs at reset values; with req=1111, next grant is ch0, not ch3.
